// File: rtl/can_acceptance_filter_bank.sv
// can_acceptance_filter_bank: multi-bank CAN acceptance filter scanned one bank per cycle
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   hdr_valid/hdr_ready          header handshake; hdr_ide, hdr_id, hdr_rtr, hdr_data0/1 carry the header
//   result_valid                 one-cycle decision pulse; result_accept/hit/index hold until the next one
//   cfg_we/cfg_re/cfg_addr       register access, bank in cfg_addr[AW-1:2], word in cfg_addr[1:0]
//   cfg_wdata/cfg_rdata          write data / registered read data
//   cfg_err                      pulses the cycle after a write dropped outside IDLE
module can_acceptance_filter_bank #(
   parameter int NUM_FILTERS = 4,
   parameter int CNT_WIDTH = 16,
   localparam int AW = $clog2(NUM_FILTERS) + 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          hdr_valid,
   output logic          hdr_ready,
   input  logic          hdr_ide,
   input  logic [28:0]   hdr_id,
   input  logic          hdr_rtr,
   input  logic [7:0]    hdr_data0,
   input  logic [7:0]    hdr_data1,
   output logic          result_valid,
   output logic          result_accept,
   output logic          result_hit,
   output logic [3:0]    result_index,
   input  logic          cfg_we,
   input  logic          cfg_re,
   input  logic [AW-1:0] cfg_addr,
   input  logic [31:0]   cfg_wdata,
   output logic [31:0]   cfg_rdata,
   output logic          cfg_err
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} st_t;
   st_t st, nst;
   logic [3:0] k, idx;
   logic [31:0] m, vb;
   logic ide, hit, any_en;
   logic [31:0] code [NUM_FILTERS];
   logic [31:0] mask [NUM_FILTERS];
   logic [2:0] ctrl [NUM_FILTERS];
   logic [CNT_WIDTH-1:0] cnt [NUM_FILTERS];
   logic [AW-1:0] bsel;
   logic [31:0] k_code, k_mask, rd_word;
   logic [2:0] k_ctrl;
   logic mk, last, wr_ok;
   assign bsel = cfg_addr >> 2;
   assign last = k == 4'(NUM_FILTERS - 1);
   assign wr_ok = cfg_we & (st == IDLE);
   always_comb begin
      k_code = '0;
      k_mask = '0;
      k_ctrl = '0;
      rd_word = '0;
      for (int i = 0; i < NUM_FILTERS; i++) begin
         if (k == 4'(i)) begin
            k_code = code[i];
            k_mask = mask[i];
            k_ctrl = ctrl[i];
         end
         if (bsel == AW'(i))
            rd_word = cfg_addr[1:0] == 2'd0 ? code[i] :
                      cfg_addr[1:0] == 2'd1 ? mask[i] :
                      cfg_addr[1:0] == 2'd2 ? {29'b0, ctrl[i]} : 32'(cnt[i]);
      end
   end
   // vb clears the positions that carry no header information so they always compare equal
   assign mk = k_ctrl[0]
             & (k_ctrl[2:1] == 2'b00 | (k_ctrl[2:1] == 2'b01 & ~ide) | (k_ctrl[2:1] == 2'b10 & ide))
             & ~|((m ^ k_code) & ~k_mask & vb);
   always_ff @(posedge clk_i) st <= rst_i ? IDLE : nst;
   always_comb nst = st == IDLE ? (hdr_valid ? SCAN : IDLE) : st == SCAN ? (last ? DONE : SCAN) : IDLE;
   always_comb begin
      hdr_ready = st == IDLE;
      result_valid = st == DONE;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         k <= '0;
         m <= '0;
         vb <= '0;
         ide <= 1'b0;
         hit <= 1'b0;
         any_en <= 1'b0;
         idx <= '0;
         result_accept <= 1'b0;
         result_hit <= 1'b0;
         result_index <= '0;
         cfg_rdata <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we & (st != IDLE);
         if (cfg_re) cfg_rdata <= rd_word;
         if (st == IDLE && hdr_valid) begin
            m <= hdr_ide ? {hdr_id, hdr_rtr, 2'b0} : {hdr_id[10:0], hdr_rtr, 4'b0, hdr_data0, hdr_data1};
            vb <= hdr_ide ? 32'hFFFF_FFFC : 32'hFFF0_FFFF;
            ide <= hdr_ide;
            k <= '0;
            hit <= 1'b0;
            any_en <= 1'b0;
            idx <= '0;
         end
         if (st == SCAN) begin
            k <= k + 4'd1;
            hit <= hit | mk;
            any_en <= any_en | k_ctrl[0];
            if (mk & ~hit) idx <= k;
            // fold in the last bank directly so the result is ready in DONE
            if (last) begin
               result_hit <= hit | mk;
               result_accept <= hit | mk | ~(any_en | k_ctrl[0]);
               result_index <= hit ? idx : mk ? k : 4'd0;
            end
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_FILTERS; i++) begin
            code[i] <= '0;
            mask[i] <= '1;
            ctrl[i] <= '0;
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_FILTERS; i++) begin
            if (st == SCAN && k == 4'(i) && mk && ~&cnt[i]) cnt[i] <= cnt[i] + 1'b1;
            if (wr_ok && bsel == AW'(i)) begin
               if (cfg_addr[1:0] == 2'd0) code[i] <= cfg_wdata;
               if (cfg_addr[1:0] == 2'd1) mask[i] <= cfg_wdata;
               if (cfg_addr[1:0] == 2'd2) ctrl[i] <= cfg_wdata[2:0];
               if (cfg_addr[1:0] == 2'd3) cnt[i] <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_can_acceptance_filter_bank.sv
// tb_can_acceptance_filter_bank: vector table plus scoreboard bench for the acceptance filter
module tb_can_acceptance_filter_bank;
   localparam int N = 4;
   localparam int CW = 2;
   localparam int AW = $clog2(N) + 2;
   typedef struct {
      logic ide;
      logic [28:0] id;
      logic rtr;
      logic [7:0] d0, d1;
      logic acc, hit;
      logic [3:0] idx;
   } vec_t;
   typedef struct {
      logic acc, hit;
      logic [3:0] idx;
      int cyc;
   } exp_t;
   logic clk = 1'b0, rst_i = 1'b1;
   logic hdr_valid = 1'b0, hdr_ready, hdr_ide = 1'b0, hdr_rtr = 1'b0;
   logic [28:0] hdr_id = '0;
   logic [7:0] hdr_data0 = '0, hdr_data1 = '0;
   logic result_valid, result_accept, result_hit;
   logic [3:0] result_index;
   logic cfg_we = 1'b0, cfg_re = 1'b0, cfg_err;
   logic [AW-1:0] cfg_addr = '0;
   logic [31:0] cfg_wdata = '0, cfg_rdata;
   int cyc = 0, n_cmp = 0, n_bad = 0;
   exp_t q[$];
   vec_t tbl[12];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   can_acceptance_filter_bank #(.NUM_FILTERS(N), .CNT_WIDTH(CW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_ide(hdr_ide), .hdr_id(hdr_id),
      .hdr_rtr(hdr_rtr), .hdr_data0(hdr_data0), .hdr_data1(hdr_data1),
      .result_valid(result_valid), .result_accept(result_accept), .result_hit(result_hit),
      .result_index(result_index),
      .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_rdata(cfg_rdata), .cfg_err(cfg_err)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (result_valid) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: result_valid at cycle %0d with nothing expected", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("res_cycle", cyc, e.cyc);
            chk("res_accept", {31'b0, result_accept}, {31'b0, e.acc});
            chk("res_hit", {31'b0, result_hit}, {31'b0, e.hit});
            if (e.hit) chk("res_index", {28'b0, result_index}, {28'b0, e.idx});
         end
      end
   end
   task automatic cfg_write(input int bank, input int word, input logic [31:0] d);
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_addr = AW'(bank * 4 + word);
      cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask
   task automatic cfg_read(input string name, input int bank, input int word, input logic [31:0] exp);
      @(negedge clk);
      cfg_re = 1'b1;
      cfg_addr = AW'(bank * 4 + word);
      @(negedge clk);
      cfg_re = 1'b0;
      chk(name, cfg_rdata, exp);
   endtask
   task automatic wait_ready();
      for (int t = 0; t < 50 && !hdr_ready; t++) @(negedge clk);
      if (!hdr_ready) chk("ready_timeout", {31'b0, hdr_ready}, 32'd1);
   endtask
   task automatic drive(input vec_t v);
      hdr_valid = 1'b1;
      hdr_ide = v.ide;
      hdr_id = v.id;
      hdr_rtr = v.rtr;
      hdr_data0 = v.d0;
      hdr_data1 = v.d1;
   endtask
   task automatic send(input vec_t v);
      exp_t e;
      wait_ready();
      drive(v);
      e.acc = v.acc;
      e.hit = v.hit;
      e.idx = v.idx;
      e.cyc = cyc + N + 1;
      q.push_back(e);
      @(negedge clk);
      hdr_valid = 1'b0;
   endtask
   task automatic drain();
      for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
      @(negedge clk);
   endtask
   task automatic run_vec(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) send(tbl[i]);
      drain();
   endtask
   function automatic vec_t mkv(input logic ide, input logic [28:0] id, input logic rtr,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic acc, input logic hit, input logic [3:0] idx);
      vec_t v;
      v.ide = ide; v.id = id; v.rtr = rtr; v.d0 = d0; v.d1 = d1;
      v.acc = acc; v.hit = hit; v.idx = idx;
      return v;
   endfunction
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      vec_t v;
      tbl[0]  = mkv(0, 29'h123,      0, 8'h00, 8'h00, 1, 0, 0);
      tbl[1]  = mkv(1, 29'h1ABCDEF0, 0, 8'h00, 8'h00, 1, 0, 0);
      tbl[2]  = mkv(0, 29'h123,      0, 8'h11, 8'h22, 1, 1, 0);
      tbl[3]  = mkv(0, 29'h124,      0, 8'h00, 8'h00, 0, 0, 0);
      tbl[4]  = mkv(1, 29'h123,      0, 8'h00, 8'h00, 0, 0, 0);
      tbl[5]  = mkv(1, 29'h1ABCDEF0, 0, 8'h00, 8'h00, 1, 1, 2);
      tbl[6]  = mkv(1, 29'h1ABCDEF1, 0, 8'h00, 8'h00, 0, 0, 0);
      tbl[7]  = mkv(0, 29'h6AF,      0, 8'hF7, 8'h80, 0, 0, 0);
      tbl[8]  = mkv(1, 29'h1ABCDEF0, 1, 8'h00, 8'h00, 1, 1, 2);
      tbl[9]  = mkv(0, 29'h123,      0, 8'h00, 8'h00, 1, 1, 1);
      tbl[10] = mkv(1, 29'h1ABCDEF0, 0, 8'h00, 8'h00, 1, 1, 2);
      tbl[11] = mkv(0, 29'h7FF,      0, 8'h00, 8'h00, 1, 1, 3);
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      chk("rst_ready", {31'b0, hdr_ready}, 32'd1);
      chk("rst_valid", {31'b0, result_valid}, 32'd0);
      chk("rst_accept", {31'b0, result_accept}, 32'd0);
      chk("rst_hit", {31'b0, result_hit}, 32'd0);
      chk("rst_index", {28'b0, result_index}, 32'd0);
      chk("rst_rdata", cfg_rdata, 32'd0);
      chk("rst_err", {31'b0, cfg_err}, 32'd0);
      cfg_read("rst_mask0", 0, 1, 32'hFFFF_FFFF);
      cfg_read("rst_code0", 0, 0, 32'h0);
      run_vec(0, 1);
      cfg_write(0, 0, 32'h2460_0000);
      cfg_write(0, 1, 32'h001F_FFFF);
      cfg_write(0, 2, 32'h3);
      run_vec(2, 4);
      cfg_read("cnt_bank0", 0, 3, 32'd1);
      cfg_write(0, 2, 32'h0);
      cfg_write(2, 0, 32'hD5E6_F780);
      cfg_write(2, 1, 32'h0000_0007);
      cfg_write(2, 2, 32'h5);
      run_vec(5, 8);
      cfg_read("cnt_bank2", 2, 3, 32'd2);
      cfg_write(1, 0, 32'h2460_0000);
      cfg_write(1, 1, 32'h001F_FFFF);
      cfg_write(1, 2, 32'h1);
      cfg_write(3, 2, 32'h3);
      run_vec(9, 11);
      cfg_read("cnt_bank1", 1, 3, 32'd1);
      cfg_read("cnt_bank3", 3, 3, 32'd2);
      cfg_read("cnt_bank2_b", 2, 3, 32'd3);
      // write dropped during a scan, ready low for the whole scan
      wait_ready();
      v = mkv(0, 29'h555, 0, 8'h00, 8'h00, 1, 1, 3);
      drive(v);
      q.push_back('{acc: 1'b1, hit: 1'b1, idx: 4'd3, cyc: cyc + N + 1});
      for (int j = 1; j <= N + 2; j++) begin
         @(negedge clk);
         hdr_valid = 1'b0;
         chk($sformatf("busy_ready_%0d", j), {31'b0, hdr_ready}, {31'b0, j == N + 2});
         if (j == 2) begin
            chk("err_before", {31'b0, cfg_err}, 32'd0);
            cfg_we = 1'b1;
            cfg_addr = AW'(0);
            cfg_wdata = 32'hDEAD_BEEF;
         end
         if (j == 3) begin
            cfg_we = 1'b0;
            chk("err_pulse", {31'b0, cfg_err}, 32'd1);
         end
         if (j == 4) chk("err_after", {31'b0, cfg_err}, 32'd0);
      end
      drain();
      cfg_read("code0_kept", 0, 0, 32'h2460_0000);
      cfg_read("cnt_bank3_b", 3, 3, 32'd3);
      // saturation on a 2-bit counter, and clear-by-write
      cfg_write(0, 1, 32'hFFFF_FFFF);
      cfg_write(0, 2, 32'h1);
      cfg_write(0, 3, 32'h1234_5678);
      cfg_read("cnt_clear", 0, 3, 32'd0);
      v = mkv(0, 29'h0, 0, 8'h00, 8'h00, 1, 1, 0);
      for (int i = 0; i < 5; i++) send(v);
      drain();
      cfg_read("cnt_sat0", 0, 3, 32'd3);
      cfg_read("cnt_sat3", 3, 3, 32'd3);
      // reset in the middle of a scan discards the result
      wait_ready();
      drive(mkv(0, 29'h123, 0, 8'h00, 8'h00, 1, 1, 0));
      @(negedge clk);
      hdr_valid = 1'b0;
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      chk("midrst_ready", {31'b0, hdr_ready}, 32'd1);
      chk("midrst_valid", {31'b0, result_valid}, 32'd0);
      repeat (8) @(negedge clk);
      cfg_read("midrst_ctrl0", 0, 2, 32'h0);
      cfg_read("midrst_mask1", 1, 1, 32'hFFFF_FFFF);
      cfg_read("midrst_cnt0", 0, 3, 32'h0);
      send(tbl[0]);
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/can_acceptance_filter_bank.md
# can_acceptance_filter_bank

Parametrised, multi-bank CAN acceptance filter that decides whether a received frame header is stored in the RX FIFO. It generalises the SJA1000 single/dual filter to NUM_FILTERS independent code/mask banks. Each bank has its own IDE qualifier and a saturating hit counter. Banks are scanned one per cycle by a small FSM between the bit-stream processor, which supplies headers, and the RX FIFO write logic, which consumes results.

## Interface
- NUM_FILTERS, 4, number of filter banks (1..16)
- CNT_WIDTH, 16, width of each per-bank hit counter (2..32)
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- hdr_valid  in  1  frame header available
- hdr_ready  out  1  block can accept a header
- hdr_ide  in  1  0 = standard, 1 = extended frame
- hdr_id  in  29  identifier; standard IDs in [10:0]
- hdr_rtr  in  1  RTR bit
- hdr_data0, hdr_data1  in  8 each  first two data bytes; 0 if absent
- result_valid  out  1  one-cycle pulse carrying the decision
- result_accept  out  1  frame to be stored
- result_hit  out  1  at least one enabled bank matched
- result_index  out  4  lowest matching bank index; valid when result_hit
- cfg_we  in  1  register write strobe
- cfg_re  in  1  register read strobe
- cfg_addr  in  $clog2(NUM_FILTERS)+2  bank in upper bits, word in [1:0]
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data, registered
- cfg_err  out  1  one-cycle pulse when a write is dropped

## Operation
- Per-bank registers (word: reset value):
  - 0 code: 0x00000000
  - 1 mask: 0xFFFFFFFF; 1 = don't care
  - 2 ctrl: 0; bit0 enable, bits[2:1] ide_sel (00 any, 01 standard only, 10 extended only, 11 bank never matches)
  - 3 hit count: 0; read-only, any write clears it
- Match word M, registered at header acceptance:
  - standard: {id[10:0], rtr, 4'b0, data0, data1}
  - extended: {id[28:0], rtr, 2'b0}
  - Unused bit positions are forced to "equal", regardless of mask.
- Bank k matches when all of the following hold:
  - enable = 1
  - ide_sel permits hdr_ide
  - ((M ^ code) & ~mask & valid_bits) == 0
- FSM states:
  - IDLE: hdr_ready = 1. hdr_valid & hdr_ready captures the header and moves to SCAN with k = 0.
  - SCAN: evaluates bank k each cycle. On a match, increments hit count k (saturating at all-ones) and, if no earlier hit, records k. After k = NUM_FILTERS-1, moves to DONE. All banks are always scanned; there is no early exit.
  - DONE: result_valid = 1 for one cycle, then returns to IDLE.
- result_accept = result_hit | (no bank enabled at scan time). With no bank enabled, the block accepts everything, matching SJA1000 reset behaviour.
- Every matching bank counts, not only the winner.
- Config writes are honoured only in IDLE. A write in SCAN or DONE is dropped, the register is unchanged, and cfg_err pulses in the following cycle.
- Reads are allowed in any state. cfg_rdata is valid the cycle after cfg_re and holds its value otherwise.
- Reset, including mid-scan: FSM goes to IDLE, all registers return to their reset values, and any in-flight result is discarded (no result_valid).
- Output reset values: hdr_ready 1, result_valid 0, result_accept 0, result_hit 0, result_index 0, cfg_rdata 0, cfg_err 0.
- result_* hold their values until the next DONE.

## Timing
- Header accepted at cycle T:
  - banks 0..N-1 are scanned in cycles T+1..T+N
  - result_valid is high in cycle T+N+1
  - hdr_ready is low from T+1 through T+N+1 and high again in T+N+2
- Throughput: one header every N+2 cycles. There is no result backpressure; the consumer must sample result_* in the result_valid cycle.
- A hit count read during SCAN returns the pre- or post-increment value depending on whether bank k has been visited. This is deterministic by cycle.

## Test plan
- Reset, no banks enabled (N=4): standard id 0x123 accepted at T → result_valid at T+5, accept=1, hit=0.
- Bank0 code 0x24600000, mask 0x001FFFFF, ctrl 0x3:
  - standard id 0x123 → accept=1, hit=1, index=0
  - standard id 0x124 → accept=0, hit=0
  - bank0 hit count reads 1
- Bank2 code 0xD5E6F780, mask 0x00000007, ctrl 0x5:
  - extended id 0x1ABCDEF0 → index=2
  - standard frame whose match word equals the code → rejected
- Banks 1 and 3 both match the same header → index=1, both hit counts increment to 1.
- Write to bank0 code at T+2 during a scan → cfg_err pulse at T+3, code reads back unchanged.
- Mid-scan reset → no result_valid, hdr_ready=1 the cycle after reset.
- CNT_WIDTH=2, 5 matching frames on bank0 → hit count saturates at 3.
- Writing count word → reads 0.
